// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared SHA-1 controller types, round constants and digest initial values
package sha1_pkg;

    localparam int SHA1_ROUNDS = 80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } sha1_state_e;

    localparam logic [31:0] SHA1_K0 = 32'h5A827999;
    localparam logic [31:0] SHA1_K1 = 32'h6ED9EBA1;
    localparam logic [31:0] SHA1_K2 = 32'h8F1BBCDC;
    localparam logic [31:0] SHA1_K3 = 32'hCA62C1D6;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

    function automatic logic [31:0] sha1_k(input logic [1:0] f_sel);
        case (f_sel)
            2'd0:    sha1_k = SHA1_K0;
            2'd1:    sha1_k = SHA1_K1;
            2'd2:    sha1_k = SHA1_K2;
            default: sha1_k = SHA1_K3;
        endcase
    endfunction

endpackage

// File: rtl/sha1_round_cnt.sv
// rtl/sha1_round_cnt.sv - round index counter with round-function select and Kt decode
module sha1_round_cnt
    import sha1_pkg::*;
#(
    parameter int ROUNDS = SHA1_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [6:0]  round_t_o,
    output logic        last_o,
    output logic [1:0]  f_sel_o,
    output logic [31:0] k_const_o
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    logic [6:0] round_t_q;
    logic [6:0] round_t_d;
    logic [1:0] grp;

    assign round_t_o = round_t_q;
    assign last_o    = en_i && (round_t_q == LAST_T);

    // The counter wraps to 0 on the last round so FINAL and IDLE always see t=0.
    always_comb begin
        round_t_d = round_t_q;
        if (clr_i) begin
            round_t_d = 7'd0;
        end else if (en_i) begin
            round_t_d = last_o ? 7'd0 : round_t_q + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_t_q <= 7'd0;
        end else begin
            round_t_q <= round_t_d;
        end
    end

    always_comb begin
        grp       = 2'd0;
        f_sel_o   = 2'd0;
        k_const_o = 32'd0;
        if (en_i) begin
            if (round_t_q < 7'd20) begin
                grp = 2'd0;
            end else if (round_t_q < 7'd40) begin
                grp = 2'd1;
            end else if (round_t_q < 7'd60) begin
                grp = 2'd2;
            end else begin
                grp = 2'd3;
            end
            f_sel_o   = grp;
            k_const_o = sha1_k(grp);
        end
    end

endmodule

// File: rtl/sha1_round_ctrl.sv
// rtl/sha1_round_ctrl.sv - SHA-1 block sequencer: IDLE -> ROUND x ROUNDS -> FINAL
// Optional abort input enabled by defining SHA1_ABORT_EN.
module sha1_round_ctrl
    import sha1_pkg::*;
#(
    parameter int ROUNDS = SHA1_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blk_valid,
    input  logic        blk_first,
`ifdef SHA1_ABORT_EN
    input  logic        abort,
`endif
    output logic        blk_ready,
    output logic        w_load,
    output logic        hash_init,
    output logic        round_en,
    output logic [6:0]  round_t,
    output logic [1:0]  f_sel,
    output logic [31:0] k_const,
    output logic        digest_add,
    output logic        done
);

    sha1_state_e state_q;
    logic        blk_ready_q;
    logic        round_en_q;
    logic        final_q;
    logic        accept;
    logic        abort_w;
    logic        last_round;

`ifdef SHA1_ABORT_EN
    assign abort_w = abort && (state_q != ST_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Gating with rst_n keeps every strobe low for the whole time reset is held.
    assign blk_ready  = blk_ready_q && rst_n;
    assign accept     = blk_valid && blk_ready;
    assign w_load     = accept;
    assign hash_init  = accept && blk_first;
    assign round_en   = round_en_q;
    assign digest_add = final_q && !abort_w;
    assign done       = final_q && !abort_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            blk_ready_q <= 1'b1;
            round_en_q  <= 1'b0;
            final_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_ROUND;
                        blk_ready_q <= 1'b0;
                        round_en_q  <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    if (abort_w) begin
                        state_q     <= ST_IDLE;
                        blk_ready_q <= 1'b1;
                        round_en_q  <= 1'b0;
                    end else if (last_round) begin
                        state_q    <= ST_FINAL;
                        round_en_q <= 1'b0;
                        final_q    <= 1'b1;
                    end
                end
                ST_FINAL: begin
                    state_q     <= ST_IDLE;
                    blk_ready_q <= 1'b1;
                    final_q     <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    blk_ready_q <= 1'b1;
                    round_en_q  <= 1'b0;
                    final_q     <= 1'b0;
                end
            endcase
        end
    end

    sha1_round_cnt #(
        .ROUNDS (ROUNDS)
    ) u_round_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (abort_w),
        .en_i      (state_q == ST_ROUND),
        .round_t_o (round_t),
        .last_o    (last_round),
        .f_sel_o   (f_sel),
        .k_const_o (k_const)
    );

endmodule
